// File: rtl/field_lock_ctrl.sv
// Playfield owner: serial 4x4 collision check / lock, then full-row clear with shift-down.
// Latency: check/hit 17 cycles, lock 53+2k; cmd_ready low while busy (no command queueing).
module field_lock_ctrl #(
  parameter int COLS = 20,
  parameter int ROWS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 field_clr,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [4:0]           cmd_pos_x,
  input  logic [4:0]           cmd_pos_y,
  input  logic [15:0]          cmd_matrix,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [2:0]           rsp_lines,
  output logic                 busy,
  output logic [8:0]           cur_index,
  output logic [COLS*ROWS-1:0] field_background
);

  localparam int FW = COLS * ROWS;
  localparam int IW = $clog2(FW);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WRITE, S_LINE, S_SHIFT, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   field_q;
  logic [FW-1:0]   field_shift;
  logic            op_q;
  logic [4:0]      pos_x_q, pos_y_q;
  logic [15:0]     mat_q;
  logic [3:0]      cnt_q;
  logic [RW-1:0]   row_ptr_q;
  logic            hit_q;
  logic [2:0]      lines_q;

  logic [5:0]      col6, row6;
  logic [11:0]     idx_full;
  logic [IW-1:0]   cell_idx;
  logic            in_bounds, cell_on, cell_hit, row_full;

  // Counter bits [1:0] walk columns, [3:2] walk rows of the 4x4 matrix.
  assign col6      = {1'b0, pos_x_q} + {4'b0, cnt_q[1:0]};
  assign row6      = {1'b0, pos_y_q} + {4'b0, cnt_q[3:2]};
  assign in_bounds = (col6 < 6'(COLS)) && (row6 < 6'(ROWS));
  assign idx_full  = 12'(row6) * 12'(COLS) + 12'(col6);
  assign cell_idx  = IW'(idx_full);
  assign cell_on   = mat_q[cnt_q];
  assign cell_hit  = cell_on && (in_bounds ? field_q[cell_idx] : 1'b1);
  assign row_full  = &field_q[int'(row_ptr_q)*COLS +: COLS];

  // Rows 0..row_ptr drop by one; rows below the cleared row stay put.
  always_comb begin
    field_shift = field_q;
    field_shift[COLS-1:0] = '0;
    for (int i = 1; i < ROWS; i++) begin
      if (RW'(i) <= row_ptr_q)
        field_shift[i*COLS +: COLS] = field_q[(i-1)*COLS +: COLS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!field_clr && cmd_valid) state_d = S_SCAN;
      S_SCAN:  if (cnt_q == 4'd15)
                 state_d = (op_q && !(hit_q || cell_hit)) ? S_WRITE : S_RESP;
      S_WRITE: if (cnt_q == 4'd15) state_d = S_LINE;
      S_LINE: begin
        if (row_full)               state_d = S_SHIFT;
        else if (row_ptr_q == '0)   state_d = S_RESP;
      end
      S_SHIFT: state_d = S_LINE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      field_q   <= '0;
      op_q      <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      mat_q     <= '0;
      cnt_q     <= '0;
      row_ptr_q <= '0;
      hit_q     <= 1'b0;
      lines_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q   <= '0;
          hit_q   <= 1'b0;
          lines_q <= '0;
          if (field_clr) begin
            field_q <= '0;
          end else if (cmd_valid) begin
            op_q    <= cmd_op;
            pos_x_q <= cmd_pos_x;
            pos_y_q <= cmd_pos_y;
            mat_q   <= cmd_matrix;
          end
        end
        S_SCAN: begin
          hit_q <= hit_q | cell_hit;
          cnt_q <= cnt_q + 4'd1;
        end
        S_WRITE: begin
          if (cell_on && in_bounds) field_q[cell_idx] <= 1'b1;
          cnt_q     <= cnt_q + 4'd1;
          row_ptr_q <= RW'(ROWS - 1);
        end
        S_LINE: begin
          if (!row_full && row_ptr_q != '0) row_ptr_q <= row_ptr_q - RW'(1);
        end
        S_SHIFT: begin
          field_q <= field_shift;
          if (lines_q != 3'd7) lines_q <= lines_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_index = '0;
    if (state_q == S_SCAN || state_q == S_WRITE)
      cur_index = 9'(idx_full);
    else if (state_q == S_LINE || state_q == S_SHIFT)
      cur_index = 9'(int'(row_ptr_q) * COLS);
  end

  assign cmd_ready        = (state_q == S_IDLE) && !field_clr;
  assign busy             = (state_q != S_IDLE);
  assign rsp_valid        = (state_q == S_RESP);
  assign rsp_hit          = rsp_valid && hit_q;
  assign rsp_lines        = rsp_valid ? lines_q : 3'd0;
  assign field_background = field_q;

endmodule

// File: tb/tb_field_lock_ctrl.sv
// Directed bench for field_lock_ctrl: latency, hit, line-clear and reset/abort cases.
module tb_field_lock_ctrl;

  localparam int COLS = 20;
  localparam int ROWS = 20;
  localparam int FW   = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst;
  logic          field_clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [4:0]    cmd_pos_x;
  logic [4:0]    cmd_pos_y;
  logic [15:0]   cmd_matrix;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [2:0]    rsp_lines;
  logic          busy;
  logic [8:0]    cur_index;
  logic [FW-1:0] field_background;

  int n_pass  = 0;
  int n_total = 0;
  logic [FW-1:0] exp_field;

  always #5 clk = ~clk;

  field_lock_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .field_clr(field_clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pos_x(cmd_pos_x), .cmd_pos_y(cmd_pos_y), .cmd_matrix(cmd_matrix),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_lines(rsp_lines),
    .busy(busy), .cur_index(cur_index), .field_background(field_background)
  );

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one command, measure its latency in cycles after the accept edge N,
  // and check the response plus its one-cycle width.
  task automatic run_cmd(input string tag, input logic op, input logic [4:0] x,
                         input logic [4:0] y, input logic [15:0] mat,
                         input int exp_lat, input logic exp_hit, input logic [2:0] exp_lines);
    int lat;
    cmd_op = op; cmd_pos_x = x; cmd_pos_y = y; cmd_matrix = mat; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, FW'(lat), FW'(exp_lat));
    chk({tag, "_hit"}, FW'(rsp_hit), FW'(exp_hit));
    chk({tag, "_lines"}, FW'(rsp_lines), FW'(exp_lines));
    @(posedge clk); #1;
    chk({tag, "_rsp_1cyc"}, FW'(rsp_valid), FW'(0));
    chk({tag, "_ready"}, FW'(cmd_ready), FW'(1));
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; field_clr = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_pos_x = '0; cmd_pos_y = '0; cmd_matrix = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_rsp_valid", FW'(rsp_valid), FW'(0));
    chk("rst_rsp_hit",   FW'(rsp_hit),   FW'(0));
    chk("rst_rsp_lines", FW'(rsp_lines), FW'(0));
    chk("rst_busy",      FW'(busy),      FW'(0));
    chk("rst_cur_index", FW'(cur_index), FW'(0));
    chk("rst_ready",     FW'(cmd_ready), FW'(1));
    chk("rst_field",     field_background, '0);

    run_cmd("chk_0_18", 1'b0, 5'd0, 5'd18, 16'h0033, 17, 1'b0, 3'd0);
    chk("chk_0_18_field", field_background, '0);
    run_cmd("chk_0_19", 1'b0, 5'd0, 5'd19, 16'h0033, 17, 1'b1, 3'd0);
    run_cmd("chk_19_0", 1'b0, 5'd19, 5'd0, 16'h0033, 17, 1'b1, 3'd0);

    exp_field = '0;
    exp_field[360] = 1'b1; exp_field[361] = 1'b1;
    exp_field[380] = 1'b1; exp_field[381] = 1'b1;
    run_cmd("lock_0_18", 1'b1, 5'd0, 5'd18, 16'h0033, 53, 1'b0, 3'd0);
    chk("lock_0_18_field", field_background, exp_field);
    run_cmd("relock", 1'b1, 5'd0, 5'd18, 16'h0033, 17, 1'b1, 3'd0);
    chk("relock_field", field_background, exp_field);
    run_cmd("empty_lock", 1'b1, 5'd3, 5'd3, 16'h0000, 53, 1'b0, 3'd0);
    chk("empty_lock_field", field_background, exp_field);

    // field_clr wins over a simultaneous command
    field_clr = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_matrix = 16'h0001;
    #1 chk("clr_ready_low", FW'(cmd_ready), FW'(0));
    @(posedge clk); #1;
    field_clr = 1'b0; cmd_valid = 1'b0;
    chk("clr_field", field_background, '0);
    chk("clr_not_busy", FW'(busy), FW'(0));

    // one full bottom row cleared by the fifth I-piece
    for (int i = 0; i < 4; i++)
      run_cmd("row19", 1'b1, 5'(4*i), 5'd19, 16'h000F, 53, 1'b0, 3'd0);
    exp_field = '0;
    for (int b = 380; b < 396; b++) exp_field[b] = 1'b1;
    chk("row19_partial", field_background, exp_field);
    run_cmd("row19_full", 1'b1, 5'd16, 5'd19, 16'h000F, 55, 1'b0, 3'd1);
    chk("row19_full_field", field_background, '0);

    // two rows cleared; a lone cell on row 17 drops two rows to row 19
    run_cmd("lone", 1'b1, 5'd0, 5'd17, 16'h0001, 53, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++)
      run_cmd("two_rows", 1'b1, 5'(4*i), 5'd18, 16'h00FF, 53, 1'b0, 3'd0);
    run_cmd("two_rows_full", 1'b1, 5'd16, 5'd18, 16'h00FF, 57, 1'b0, 3'd2);
    exp_field = '0;
    exp_field[380] = 1'b1;
    chk("two_rows_field", field_background, exp_field);

    // reset mid-lock aborts with no response
    field_clr = 1'b1;
    @(posedge clk); #1;
    field_clr = 1'b0;
    cmd_op = 1'b1; cmd_pos_x = 5'd0; cmd_pos_y = 5'd18; cmd_matrix = 16'h0033; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1; seen = 1'b0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (rsp_valid) seen = 1'b1;
    chk("abort_no_rsp", FW'(seen), FW'(0));
    chk("abort_idle",   FW'(busy), FW'(0));
    chk("abort_ready",  FW'(cmd_ready), FW'(1));
    chk("abort_field",  field_background, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
